// File: rtl/aging_uart_framer_if.sv
// ---------------------------------------------------------------------------
// aging_uart_framer_if : measurement handshake + TX-stage byte port | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface aging_uart_framer_if #(
  parameter int DATA_W = 24,
  parameter int ID_W   = 4
);
  logic              meas_valid;
  logic [DATA_W-1:0] meas_data;
  logic [ID_W-1:0]   meas_id;
  logic              meas_ready;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_en;

  // master: measurement source plus TX stage; slave: the framer
  modport master (
    output meas_valid, meas_data, meas_id, tx_busy,
    input  meas_ready, tx_data, tx_en
  );

  modport slave (
    input  meas_valid, meas_data, meas_id, tx_busy,
    output meas_ready, tx_data, tx_en
  );
endinterface

`default_nettype wire

// File: rtl/aging_uart_framer.sv
// ---------------------------------------------------------------------------
// aging_uart_framer : frames one sensor measurement as HDR/ID/DATA/CSUM bytes | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aging_uart_framer #(
  parameter int          DATA_W = 24,
  parameter int          ID_W   = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                 clk,
  input  logic                 RSTn,
  aging_uart_framer_if.slave   bus,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int SH_W   = NBYTES * 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ID   = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] byte_idx;
  logic [SH_W-1:0]  shadow;
  logic [7:0]       id_byte;
  logic [7:0]       csum;
  logic [15:0]      frame_count;
  logic [7:0]       data_byte;
  logic             accept;
  logic             write;

  assign frame_cnt = frame_count;

  // MSB-first selection of the current data byte from the shadow word
  always_comb begin
    data_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_idx == CNT_W'(k)) begin
        data_byte = shadow[(NBYTES-1-k)*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    write          = 1'b0;
    bus.meas_ready = 1'b0;
    bus.tx_data    = 8'h00;
    case (state)
      S_IDLE: begin
        bus.meas_ready = 1'b1;
        if (bus.meas_valid) begin
          accept     = 1'b1;
          next_state = S_HDR;
        end
      end
      S_HDR: begin
        bus.tx_data = HEADER;
        write       = ~bus.tx_busy;
        if (write) next_state = S_ID;
      end
      S_ID: begin
        bus.tx_data = id_byte;
        write       = ~bus.tx_busy;
        if (write) next_state = S_DATA;
      end
      S_DATA: begin
        bus.tx_data = data_byte;
        write       = ~bus.tx_busy;
        if (write && (byte_idx == LAST_IDX)) next_state = S_CSUM;
      end
      S_CSUM: begin
        bus.tx_data = csum;
        write       = ~bus.tx_busy;
        if (write) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    bus.tx_en = write;
  end

  // Shadow registers only load on acceptance, so input changes mid-frame are ignored
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      shadow  <= '0;
      id_byte <= 8'h00;
    end else if (accept) begin
      shadow  <= SH_W'(bus.meas_data);
      id_byte <= 8'(bus.meas_id);
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      byte_idx <= '0;
      csum     <= 8'h00;
    end else if (accept) begin
      byte_idx <= '0;
      csum     <= 8'h00;
    end else if (write) begin
      if (state == S_ID) begin
        csum <= csum + id_byte;
      end else if (state == S_DATA) begin
        csum     <= csum + data_byte;
        byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      if (write && (state == S_CSUM)) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
